// File: rtl/sram_port_arbiter.sv
// Shares one sram-like req/addr_ok/data_ok port between the IF (inst) and EXE (data) requesters.
// Address phases are granted round-robin with grant locking; responses are routed by an in-order owner FIFO.
module sram_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             inst_req,
    input  logic             inst_wr,
    input  logic [1:0]       inst_size,
    input  logic [3:0]       inst_wstrb,
    input  logic [31:0]      inst_addr,
    input  logic [31:0]      inst_wdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,

    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,

    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       mem_size,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata,

    output logic [PTR_W:0]   outstanding,
    output logic             resp_err
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic             lock_valid;
    logic             lock_id;
    logic             last_id;
    logic [DEPTH-1:0] owner_fifo;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic full;
    logic grant_valid;
    logic grant_id;
    logic granted_req;
    logic locked_req;
    logic accept;
    logic ret;
    logic head;

    assign full = (count == FULL_COUNT);

    // Full is taken from the registered count so a same-cycle return never feeds back into the grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!full) begin
            if (lock_valid) begin
                grant_valid = 1'b1;
                grant_id    = lock_id;
            end else if (inst_req && data_req) begin
                grant_valid = 1'b1;
                grant_id    = ~last_id;
            end else if (inst_req) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (data_req) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign granted_req = grant_id ? data_req : inst_req;
    assign locked_req  = lock_id ? data_req : inst_req;

    assign mem_req   = grant_valid & granted_req;
    assign mem_wr    = grant_id ? data_wr    : inst_wr;
    assign mem_size  = grant_id ? data_size  : inst_size;
    assign mem_wstrb = grant_id ? data_wstrb : inst_wstrb;
    assign mem_addr  = grant_id ? data_addr  : inst_addr;
    assign mem_wdata = grant_id ? data_wdata : inst_wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~grant_id;
    assign data_addr_ok = accept & grant_id;

    assign ret          = mem_data_ok & (count != '0);
    assign head         = owner_fifo[rd_ptr];
    assign inst_data_ok = ret & ~head;
    assign data_data_ok = ret & head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign outstanding = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
            last_id    <= 1'b0;
        end else begin
            if (accept) begin
                lock_valid <= 1'b0;
                last_id    <= grant_id;
            end else if (mem_req) begin
                lock_valid <= 1'b1;
                lock_id    <= grant_id;
            end else if (lock_valid && !locked_req) begin
                lock_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            owner_fifo[wr_ptr] <= grant_id;
        end
    end

    // Pointers are PTR_W wide so increments wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ret) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !ret) begin
                count <= count + 1'b1;
            end else if (ret && !accept) begin
                count <= count - 1'b1;
            end
            if (mem_data_ok && (count == '0)) begin
                resp_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one sram-like memory port between the IF-stage instruction requester and the EXE-stage data requester. Both use the req / addr_ok / data_ok protocol.
- Grants address phases round-robin and locks a grant until it is accepted.
- Records the owner of each accepted request in an in-order FIFO. Each data_ok/rdata return is routed back to the requester that issued it.
- Sits between the CPU core's inst/data sram interfaces and the single downstream memory or bus bridge port.

Parameters:
- DEPTH, 4: maximum outstanding accepted-but-not-returned requests. Must be a power of two, at least 2.
- PTR_W, 2: log2(DEPTH). FIFO pointer width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction request valid
- inst_wr  in  1  instruction write flag; forwarded as-is
- inst_size  in  2  access size
- inst_wstrb  in  4  byte strobes
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  instruction address phase accepted
- inst_data_ok  out  1  instruction response valid
- inst_rdata  out  32  instruction response data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data requester, same meaning as the inst_* inputs
- data_addr_ok  out  1  data address phase accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data response data
- mem_req  out  1  downstream request valid
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  payload of the granted requester
- mem_addr_ok  in  1  downstream address phase accepted
- mem_data_ok  in  1  downstream response valid; responses are in order
- mem_rdata  in  32  downstream response data
- outstanding  out  PTR_W+1  current FIFO occupancy
- resp_err  out  1  sticky error flag: mem_data_ok arrived with FIFO empty

Behaviour:
- State registers:
  - lock_valid and lock_id (0 = inst, 1 = data)
  - last_id
  - owner FIFO: DEPTH entries, 1 bit each, with rd_ptr, wr_ptr and count
  - resp_err
- Reset values (asynchronous, while resetn = 0): lock_valid = 0, lock_id = 0, last_id = 0, rd_ptr = 0, wr_ptr = 0, count = 0, resp_err = 0.
  - Resulting outputs: mem_req = 0, all addr_ok/data_ok = 0, outstanding = 0.
- Grant selection (combinational):
  - full = (count == DEPTH). If full, mem_req = 0 and no grant is issued.
  - Else if lock_valid, grant = lock_id.
  - Else if only one requester has req = 1, grant goes to it.
  - Else if both have req = 1, grant = ~last_id.
  - mem_req = granted requester's req. The mem_* payload is muxed from the granted requester, or from inst when there is no grant.
- Lock rule:
  - Set lock_valid = 1 and lock_id = grant when mem_req = 1 and mem_addr_ok = 0.
  - Clear lock_valid on mem_req & mem_addr_ok.
  - A locked grant is never switched.
  - If the locked requester drops req (pipeline cancel), clear lock_valid at the next edge.
- Accept: on mem_req & mem_addr_ok:
  - push grant into FIFO[wr_ptr], wr_ptr += 1 (wraps mod DEPTH), last_id = grant
  - pulse the granted side's *_addr_ok in the same cycle (combinational from mem_addr_ok)
  - the other side's addr_ok stays 0
- Return: on mem_data_ok with count != 0:
  - head = FIFO[rd_ptr]; rd_ptr += 1 (wraps)
  - assert inst_data_ok if head = 0, or data_data_ok if head = 1, in the same cycle
  - both *_rdata are driven with mem_rdata unconditionally
- Empty return: mem_data_ok with count == 0 sets resp_err = 1 (sticky until reset). No data_ok is asserted and pointers are unchanged.
- Count update on simultaneous accept and return: count is unchanged and both pointers advance.
  - Accept is blocked when full, even if a return occurs in the same cycle (full is evaluated from registered count). This is intentional and keeps the path free of combinational loops.
- Latency: zero-cycle pass-through for both address and response phases. The block adds no bubbles except when full.
- Reset mid-operation clears the FIFO and lock. Any later stray mem_data_ok for pre-reset requests sets resp_err.

Test Plan:
- Reset then idle: resetn = 0 → mem_req = 0, outstanding = 0, resp_err = 0. Release reset, inst_req = 1, addr 0x1c000000, mem_addr_ok = 1 → mem_addr = 0x1c000000, inst_addr_ok = 1, outstanding = 1 next cycle.
- Round-robin: both requesters hold req and mem_addr_ok = 1 every cycle → grants alternate data, inst, data, inst. The first grant is data because last_id resets to 0.
- Lock: data granted with mem_addr_ok = 0 for 3 cycles while inst_req rises in cycle 2 → mem_addr stays the data address all 3 cycles. Data is accepted on the 4th cycle, then inst is granted.
- Routing: accept inst, data, inst (mem_rdata returns 0xA, 0xB, 0xC in order) → inst_data_ok with 0xA, data_data_ok with 0xB, inst_data_ok with 0xC. outstanding counts 3→0.
- Full/wrap: 4 accepts with no return → outstanding = 4 and mem_req = 0 despite inst_req = 1. Return one → next cycle mem_req = 1. Repeat for 10 requests total and check owner order across pointer wrap.
- Error: mem_data_ok = 1 with outstanding = 0 → resp_err = 1 and both data_ok = 0. resp_err stays 1 until resetn is asserted.
